// File: rtl/nios_timer_pkg.sv
// Shared register map, bit indices and halfword helpers for the parametrised interval timer.
package nios_timer_pkg;

  localparam int unsigned MAX_COUNTER_WIDTH = 64;

  localparam logic [3:0] ADDR_STATUS   = 4'd0;
  localparam logic [3:0] ADDR_CONTROL  = 4'd1;
  localparam logic [3:0] ADDR_PERIOD0  = 4'd2;
  localparam logic [3:0] ADDR_PERIOD3  = 4'd5;
  localparam logic [3:0] ADDR_SNAP0    = 4'd6;
  localparam logic [3:0] ADDR_SNAP3    = 4'd9;
  localparam logic [3:0] ADDR_PRESCALE = 4'd10;

  localparam int unsigned STATUS_TO     = 0;
  localparam int unsigned STATUS_RUN    = 1;
  localparam int unsigned CONTROL_ITO   = 0;
  localparam int unsigned CONTROL_CONT  = 1;
  localparam int unsigned CONTROL_START = 2;
  localparam int unsigned CONTROL_STOP  = 3;

  function automatic logic [15:0] halfword(input logic [MAX_COUNTER_WIDTH-1:0] v,
                                           input logic [1:0] idx);
    return v[16*idx +: 16];
  endfunction

  function automatic logic [MAX_COUNTER_WIDTH-1:0] merge_halfword(
      input logic [MAX_COUNTER_WIDTH-1:0] v, input logic [1:0] idx, input logic [15:0] data);
    logic [MAX_COUNTER_WIDTH-1:0] r;
    r = v;
    r[16*idx +: 16] = data;
    return r;
  endfunction

endpackage

// File: rtl/nios_timer_prescaler.sv
// Tick divider for the interval timer: divides clk by (PRESCALE+1) while running.
module nios_timer_prescaler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [15:0] writedata,
  input  logic        run,
  input  logic        restart,
  output logic [15:0] prescale,
  output logic        tick
);

  logic [15:0] div_cnt;

  // >= keeps the divider from running away if PRESCALE shrinks below div_cnt
  assign tick = run && (div_cnt >= prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      div_cnt  <= '0;
    end else begin
      if (wr) prescale <= writedata;
      if (restart)  div_cnt <= '0;
      else if (run) div_cnt <= tick ? '0 : div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/nios_param_interval_timer.sv
// Parametrised Avalon-MM interval timer; NIOS_TIMER_PRESCALER_EN adds the PRESCALE
// register at address 10 and a clock divider on the count tick.
module nios_param_interval_timer
  import nios_timer_pkg::*;
#(
  parameter int unsigned                  COUNTER_WIDTH = 32,
  parameter logic [MAX_COUNTER_WIDTH-1:0] RESET_PERIOD  = 64'h0000_0000_0000_C34F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int unsigned W      = COUNTER_WIDTH;
  localparam int unsigned NUM_HW = (W + 15) / 16;
  localparam logic [W-1:0] RST_PERIOD = RESET_PERIOD[W-1:0];

  logic [W-1:0] counter, period, snap, cnt_next;
  logic         run, to, zero_d, reload;
  logic [3:0]   ctrl;
  logic         tick;
  logic [15:0]  prescale_rd, rd_mux;
  logic [1:0]   idx_p, idx_s;
  logic         wr, wr_status, wr_control, wr_period, wr_snap;
  logic         start, stop, at_zero, timeout, one_shot_end;

  always_comb begin
    wr         = chipselect && !write_n;
    idx_p      = 2'(address - ADDR_PERIOD0);
    idx_s      = 2'(address - ADDR_SNAP0);
    wr_status  = wr && (address == ADDR_STATUS);
    wr_control = wr && (address == ADDR_CONTROL);
    // halfwords wholly above the counter width are not there: no update, no reload
    wr_period  = wr && (address >= ADDR_PERIOD0) && (address <= ADDR_PERIOD3)
                 && (32'(idx_p) < NUM_HW);
    wr_snap    = wr && (address >= ADDR_SNAP0) && (address <= ADDR_SNAP3);
    start      = wr_control && writedata[CONTROL_START];
    stop       = wr_control && writedata[CONTROL_STOP];
    at_zero    = (counter == '0);
    timeout    = at_zero && !zero_d;
    cnt_next   = at_zero ? period : counter - W'(1);
    one_shot_end = run && tick && (cnt_next == '0) && !ctrl[CONTROL_CONT];
  end

  always_comb begin
    rd_mux = '0;
    case (address) inside
      ADDR_STATUS: begin
        rd_mux[STATUS_TO]  = to;
        rd_mux[STATUS_RUN] = run;
      end
      ADDR_CONTROL:                rd_mux = {12'd0, ctrl};
      [ADDR_PERIOD0:ADDR_PERIOD3]: rd_mux = halfword(MAX_COUNTER_WIDTH'(period), idx_p);
      [ADDR_SNAP0:ADDR_SNAP3]:     rd_mux = halfword(MAX_COUNTER_WIDTH'(snap), idx_s);
      ADDR_PRESCALE:               rd_mux = prescale_rd;
      default:                     rd_mux = '0;
    endcase
  end

`ifdef NIOS_TIMER_PRESCALER_EN
  logic wr_prescale;
  assign wr_prescale = wr && (address == ADDR_PRESCALE);

  nios_timer_prescaler u_prescaler (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (wr_prescale),
    .writedata (writedata),
    .run       (run),
    .restart   (start || reload),
    .prescale  (prescale_rd),
    .tick      (tick)
  );
`else
  assign tick        = 1'b1;
  assign prescale_rd = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter  <= RST_PERIOD;
      period   <= RST_PERIOD;
      snap     <= '0;
      run      <= 1'b0;
      to       <= 1'b0;
      zero_d   <= 1'b1;
      reload   <= 1'b0;
      ctrl     <= '0;
      readdata <= '0;
    end else begin
      zero_d <= at_zero;
      reload <= wr_period;
      if (wr_period)  period <= W'(merge_halfword(MAX_COUNTER_WIDTH'(period), idx_p, writedata));
      if (wr_control) ctrl <= writedata[3:0];
      if (wr_snap)    snap <= counter;
      if (timeout)        to <= 1'b1;
      else if (wr_status) to <= 1'b0;
      if (reload)           counter <= period;
      else if (run && tick) counter <= cnt_next;
      if (start)                                run <= 1'b1;
      else if (stop || reload || one_shot_end) run <= 1'b0;
      if (chipselect && write_n) readdata <= rd_mux;
    end
  end

  assign irq = to && ctrl[CONTROL_ITO];

endmodule

// File: doc/nios_param_interval_timer.md
# nios_param_interval_timer

Parametrised Avalon-MM interval timer for the per-processor Nios II subsystems; successor to the fixed-period 13-bit system timer. Counter width, reset period and interrupt behaviour are compile-time parameters, and the period is software-writable at run time. It sits on each processor's 16-bit data master as a slave and drives one level-sensitive IRQ line.

## Interface
- `COUNTER_WIDTH`, default 32: counter/period width in bits; legal range 17..64.
- `RESET_PERIOD`, default 32'h0000_C34F: period register value after reset; truncated to `COUNTER_WIDTH` bits.
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `address`  in  4: register word index.
- `chipselect`  in  1: slave select.
- `write_n`  in  1: active-low write strobe, qualified by `chipselect`.
- `writedata`  in  16: write data.
- `readdata`  out  16: registered read data; 0 at reset.
- `irq`  out  1: interrupt request, `TO && ITO`; 0 at reset.

## Operation
- Register map (16-bit words):
  - 0 STATUS: bit0 TO, bit1 RUN (read-only); any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bits[3:2] read back as written; bit2 START, bit3 STOP also act as strobes.
  - 2..5 PERIOD halfwords 0..3, LSB first.
  - 6..9 SNAP halfwords 0..3.
  - 10 PRESCALE, only with the configuration macro.
  - All other addresses read 0.
- Halfwords wholly above `COUNTER_WIDTH` read 0 and ignore writes. A partial top halfword zero-fills unused bits.
- Reset state:
  - counter = period = `RESET_PERIOD`.
  - RUN = 0, TO = 0, CONTROL = 0, SNAP = 0.
- Counting:
  - While RUN, the counter decrements by one per tick.
  - At 0 it reloads the period on the next tick, so a period value P gives a timeout every P+1 ticks.
  - If CONT = 0, reaching 0 clears RUN. The counter then holds 0 until restarted.
- Timeout: a rising edge of (counter == 0) sets TO, found by comparing with a 1-cycle-delayed copy.
- PERIOD write:
  - Updates the addressed halfword.
  - Asserts an internal force-reload pulse on the following cycle. That pulse loads counter ← period and clears RUN.
- START/STOP:
  - START sets RUN.
  - STOP, force-reload, or zero with CONT = 0 clears RUN.
  - START has priority over all stop causes in the same cycle.
- Snapshot: a write to any SNAP address copies the full counter into SNAP. Write data is ignored.
- Read-modify interactions: the counter, period and snapshot are never torn by the bus. Software owns multi-halfword consistency through the snapshot.

## Timing
- Read latency is 1 cycle: `readdata` reflects the register state at the edge where `chipselect` is sampled.
- Writes take effect at the sampling edge. Reads have no wait states.
- Counter reaches 0 at edge t → TO = 1 and `irq` = 1 (if ITO) after edge t+1.
- STATUS write coinciding with a new timeout event: TO stays set, because the timeout wins.
- START write at edge t → first decrement at edge t+1.
- PERIOD write at edge t → reload and RUN = 0 at edge t+1 → value visible via SNAP from edge t+2.
- Mid-operation reset: all state returns to reset values asynchronously. The counter reloads `RESET_PERIOD`, not the last written period.

## Configuration
- `NIOS_TIMER_PRESCALER_EN`, defined:
  - Adds the 16-bit PRESCALE register at address 10, reset 0.
  - A prescale counter divides `clk` by (PRESCALE+1) to generate the tick. It runs only while RUN and restarts from 0 on START or force-reload.
  - PRESCALE = 0 gives the same behaviour as the macro undefined.
- Undefined: tick = every `clk`. Address 10 reads 0 and writes are ignored. No prescaler logic is instantiated.

## Structure
- Package `nios_timer_pkg`:
  - register address constants (`ADDR_STATUS` … `ADDR_PRESCALE`);
  - STATUS/CONTROL bit indices;
  - `MAX_COUNTER_WIDTH = 64`.
- Sub-module `nios_timer_prescaler`: PRESCALE register, divide counter, tick output. Instantiated only under the macro.
- Top level: bus decode, period/snapshot halfword banks, counter, RUN/TO logic.

## Test plan
- Reset, then read all addresses → STATUS = 0, CONTROL = 0, PERIOD halfwords = `RESET_PERIOD` slices, SNAP = 0, `irq` = 0.
- `COUNTER_WIDTH` = 32: write PERIOD = 0x0000_0004; CONTROL = 0x0007 (ITO, CONT, START) → timeouts every 5 cycles; `irq` high one cycle after each zero; STATUS write clears TO, and TO re-sets 5 cycles later.
- One-shot: PERIOD = 9, CONTROL = 0x0005 → single TO after 10 cycles; RUN = 0; counter holds 0; no further TO events.
- Snapshot while running with PERIOD = 0x0001_0000 → SNAP halfwords read a consistent counter value within 2 cycles of the write; halfwords 2..3 read 0.
- CONTROL write 0x000C (START + STOP) → RUN = 1. STATUS write on the same edge as a timeout → TO = 1.
- With `NIOS_TIMER_PRESCALER_EN`: PRESCALE = 3, PERIOD = 1 → timeout every 8 `clk` cycles. Without the macro, a read of address 10 returns 0.
